// File: rtl/moore_seq_detector.sv
// Moore-style serial pattern detector with a runtime-loadable PAT_LEN-bit pattern,
// overlap / non-overlap modes and a saturating match counter.
module moore_seq_detector #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 4,
    parameter int SW      = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x_in,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_data,
    input  logic               clr_cnt,
    output logic [SW-1:0]      state,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] hist;      // hist[0] is the most recent accepted bit
    logic [PAT_LEN-1:0] h_base;
    logic [PAT_LEN-1:0] h_new;
    logic [SW-1:0]      nxt_state;
    logic               restart;
    logic               hit;
    logic               nxt_full;
    int                 cur;
    int                 lim;

    // Longest suffix of the new history that is also a pattern prefix, capped at
    // one more than the bits already matched.
    always_comb begin
        cur       = int'(state);
        restart   = (cur == PAT_LEN) && !overlap;
        h_base    = restart ? '0 : hist;
        h_new     = {h_base[PAT_LEN-2:0], x_in};
        lim       = restart ? 1 : ((cur + 1 > PAT_LEN) ? PAT_LEN : cur + 1);
        nxt_state = '0;
        hit       = 1'b0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            hit = (j <= lim);
            for (int i = 0; i < j; i++) begin
                if (h_new[j-1-i] != pat[i]) hit = 1'b0;
            end
            if (hit) nxt_state = SW'(j);
        end
        nxt_full = (nxt_state == SW'(PAT_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat   <= '1;
            hist  <= '0;
            state <= '0;
            match <= 1'b0;
        end else if (pat_load) begin
            pat   <= pat_data;
            hist  <= '0;
            state <= '0;
            match <= 1'b0;
        end else if (x_valid) begin
            hist  <= h_new;
            state <= nxt_state;
            match <= nxt_full;
        end
    end

    // Clear wins over a same-cycle match entry; a load never touches the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (x_valid && !pat_load && nxt_full && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: reset, overlap/non-overlap detection,
// valid gating, load priority and counter saturation/clear.
module tb_moore_seq_detector;

    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 4;
    localparam int SW      = $clog2(PAT_LEN + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               x_in = 1'b0;
    logic               x_valid = 1'b0;
    logic               overlap = 1'b1;
    logic               pat_load = 1'b0;
    logic [PAT_LEN-1:0] pat_data = '0;
    logic               clr_cnt = 1'b0;
    logic [SW-1:0]      state;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    int errors = 0;
    int checks = 0;

    moore_seq_detector #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_data  (pat_data),
        .clr_cnt   (clr_cnt),
        .state     (state),
        .match     (match),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted bit; returns at posedge+1 so outputs can be sampled.
    task automatic bit_in(input logic b, input logic clr = 1'b0);
        x_in    = b;
        x_valid = 1'b1;
        clr_cnt = clr;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic load(input logic [PAT_LEN-1:0] p, input logic clr);
        pat_data = p;
        pat_load = 1'b1;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    logic [3:0] strm;
    int exp_ov [7] = '{1, 2, 3, 4, 2, 3, 4};
    int exp_no [7] = '{1, 2, 3, 4, 0, 1, 1};

    initial begin
        // Power-on reset and default pattern of all ones
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        rst_n = 1'b1;

        // Non-overlap seven ones: states 1,2,3,4,1,2,3 with one match
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) bit_in(1'b1);
        chk("pre_rst_state", state, 3);
        chk("pre_rst_cnt", match_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_match", match, 0);
        chk("async_rst_cnt", match_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) bit_in(1'b1);
        chk("dflt_no_match_b3", match, 0);
        bit_in(1'b1);
        chk("dflt_match_b4", match, 1);
        chk("dflt_state_b4", state, 4);

        // Overlapping detection of 1,0,1,1
        strm = 4'b1101;
        overlap = 1'b1;
        load(4'b1101, 1'b1);
        chk("load_state", state, 0);
        chk("load_clr_cnt", match_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            bit_in((i == 1 || i == 4) ? 1'b0 : 1'b1);
            chk($sformatf("ov_state_b%0d", i + 1), state, exp_ov[i]);
            chk($sformatf("ov_match_b%0d", i + 1), match, (exp_ov[i] == 4) ? 1 : 0);
        end
        chk("ov_cnt", match_cnt, 2);

        // Same stream, non-overlapping
        overlap = 1'b0;
        load(4'b1101, 1'b1);
        for (int i = 0; i < 7; i++) begin
            bit_in((i == 1 || i == 4) ? 1'b0 : 1'b1);
            chk($sformatf("no_state_b%0d", i + 1), state, exp_no[i]);
        end
        chk("no_cnt", match_cnt, 1);

        // Run of ones, overlapping: matches on bits 4..8
        overlap = 1'b1;
        load(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) bit_in(1'b1);
        chk("run_ov_cnt", match_cnt, 5);

        // Valid low holds everything, even with x_in toggling
        for (int i = 0; i < 3; i++) begin
            x_in = i[0];
            @(posedge clk);
            #1;
            chk($sformatf("hold_state_c%0d", i), state, 4);
            chk($sformatf("hold_match_c%0d", i), match, 1);
            chk($sformatf("hold_cnt_c%0d", i), match_cnt, 5);
        end

        // Load beats a concurrent valid bit; counter untouched
        x_in    = 1'b1;
        x_valid = 1'b1;
        load(4'b1111, 1'b0);
        x_valid = 1'b0;
        chk("ldpri_state", state, 0);
        chk("ldpri_match", match, 0);
        chk("ldpri_cnt", match_cnt, 5);
        bit_in(1'b1);
        chk("ldpri_next_state", state, 1);

        // Run of ones, non-overlapping: matches on bits 4 and 8
        overlap = 1'b0;
        load(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) bit_in(1'b1);
        chk("run_no_cnt", match_cnt, 2);
        chk("run_no_match", match, 1);

        // Saturation: 17 matches from 20 overlapping ones
        overlap = 1'b1;
        load(4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) begin
            bit_in(1'b1);
            if (i == 16) chk("sat_cnt_14", match_cnt, 14);
            if (i == 18) chk("sat_cnt_16th", match_cnt, 15);
        end
        chk("sat_cnt_final", match_cnt, 15);

        // Clear in the same cycle as a match entry
        load(4'b1111, 1'b0);
        chk("clr_pre_cnt", match_cnt, 15);
        for (int i = 0; i < 3; i++) bit_in(1'b1);
        bit_in(1'b1, 1'b1);
        chk("clr_match", match, 1);
        chk("clr_cnt", match_cnt, 0);
        bit_in(1'b1);
        chk("clr_then_inc", match_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised successor to the fixed 3-bit Moore state machine. Detects a runtime-programmable serial bit pattern of PAT_LEN bits on a single-bit input stream.
- Supports overlapping and non-overlapping detection modes.
- Exposes the current state (number of pattern bits matched), a registered Moore match flag and a saturating match counter.
- Sits directly under the tile top-level wrapper, fed from a ui_in bit, with outputs mapped to uo_out.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..8); the state encodes 0..PAT_LEN.
- CNT_W, 4, width of the saturating match counter.
- SW, $clog2(PAT_LEN+1), state width (derived; not for override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- x_in  input  1  serial data bit.
- x_valid  input  1  x_in is sampled only when high; when low, all state holds.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled with each valid bit.
- pat_load  input  1  loads pat_data and restarts detection.
- pat_data  input  PAT_LEN  pattern; pat_data[0] is the first bit in stream order, pat_data[PAT_LEN-1] the last.
- clr_cnt  input  1  synchronous clear of match_cnt.
- state  output  SW  current Moore state = number of pattern bits currently matched (0..PAT_LEN).
- match  output  1  high exactly while state == PAT_LEN.
- match_cnt  output  CNT_W  number of match-state entries, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = 0, match = 0, match_cnt = 0.
  - Pattern register = all ones.
  - History shift register = 0.
- Registers: a pattern register, a PAT_LEN-bit history of the most recent valid bits, the state register and the counter.
- Next-state rule on a valid cycle:
  - Let k = current state and h = the history with x_in appended.
  - Next state = the largest j with j <= min(k+1, PAT_LEN) such that the last j bits of h equal pat[0..j-1]. j = 0 always qualifies.
  - This is the KMP-equivalent Moore machine; it is computed combinationally by comparing all candidate j.
- Overlap mode: when k == PAT_LEN, the history is retained, so the suffix of a match can start a new match.
- Non-overlap mode: when k == PAT_LEN, the history is treated as empty before appending x_in, so next state is 1 if x_in == pat[0], else 0.
- Moore output:
  - match depends only on state. It rises the cycle after the clock edge that accepts the final pattern bit (1-cycle latency).
  - match stays high until the next valid bit, regardless of how many invalid cycles pass.
- x_valid low: state, history, match and match_cnt hold.
- pat_load high:
  - Pattern register <= pat_data; state <= 0; history <= 0.
  - Any concurrent valid bit is discarded.
  - match_cnt is unaffected.
- match_cnt:
  - Increments by 1 on each cycle where next state == PAT_LEN.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt clears it to 0 and takes priority over a same-cycle increment.
- Reset mid-stream: returns to the reset values immediately. A partially matched pattern is lost; the pattern register returns to all ones.
- No other outputs are driven; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/defaults: assert rst_n=0 mid-stream with state=3 -> state=0, match=0, match_cnt=0 immediately (before the next clk edge). Then, with no load, feed four 1s -> match=1 on the cycle after the 4th bit.
- Overlap: load pat_data=4'b1101 (stream 1,0,1,1), overlap=1, feed 1,0,1,1,0,1,1 -> states 1,2,3,4,2,3,4; match high after bits 4 and 7; match_cnt=2.
- Non-overlap: same pattern and stream with overlap=0 -> states 1,2,3,4,0,1,1; one match; match_cnt=1.
- Run-of-ones: pattern 1111, feed 8 ones -> overlap=1 gives match_cnt=5 (bits 4..8); overlap=0 gives match_cnt=2 (bits 4 and 8).
- Valid gating and load priority:
  - Part 1: drop x_valid for 3 cycles while state=4 -> match stays 1, state holds.
  - Part 2: pat_load together with x_valid=1 -> state=0, the bit is ignored, match_cnt is unchanged.
- Counter saturation/clear:
  - Part 1: with CNT_W=4, produce 17 matches -> match_cnt stops at 15.
  - Part 2: assert clr_cnt in the same cycle as a match entry -> match_cnt=0, match=1.
